// File: rtl/jtframe_pll_rstgen.sv
// Reset and clock-enable sequencer sitting right after the PLL.
// Qualifies the PLL lock flag, holds the system in reset for a programmed
// time, then releases it and produces a drift-free fractional clock enable.
// A PLL that never locks is re-kicked through its reset input.
module jtframe_pll_rstgen #(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 256,
    parameter int TIMEOUT     = 1048576,
    parameter int PLLRST_LEN  = 16,
    parameter int CW          = 24,
    parameter int CEN_NUM     = 1,
    parameter int CEN_DEN     = 8,
    parameter int AW          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_out,
    output logic       rstn_out,
    output logic       cen,
    output logic       ready,
    output logic [7:0] lost_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        HOLD,
        RUN,
        PLLRST
    } state_t;

    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PLLRST_LAST = CW'(PLLRST_LEN - 1);
    localparam logic [AW-1:0] NUM_W       = AW'(CEN_NUM);
    localparam logic [AW-1:0] DEN_W       = AW'(CEN_DEN);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   sum;
    logic            sync1_q, sync1_d;
    logic            locked_s_q, locked_s_d;
    logic            rst_out_q, rst_out_d;
    logic            rstn_out_q, rstn_out_d;
    logic            ready_q, ready_d;
    logic            pll_rst_q, pll_rst_d;
    logic            cen_q, cen_d;
    logic [7:0]      lost_q, lost_d;

    // Next-state, counter, lock-loss count and cen accumulator.
    always_comb begin
        sync1_d    = pll_locked;
        locked_s_d = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        lost_d     = lost_q;
        acc_d      = '0;
        cen_d      = 1'b0;
        sum        = acc_q + NUM_W;

        case (state_q)
            WAIT_LOCK: begin
                if (locked_s_q)            state_d = SETTLE;
                else if (cnt_q == TO_LAST) state_d = PLLRST;
            end
            SETTLE: begin
                if (!locked_s_q)             state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!locked_s_q)             state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                // Counter is unused here; park it so it never wraps.
                cnt_d = '0;
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end
            end
            PLLRST: begin
                // Lock state is deliberately ignored while the PLL is kicked.
                if (cnt_q == PLLRST_LAST) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Accumulate only once already in RUN, so the first pulse lands
        // ceil(DEN/NUM) cycles after release.
        if (state_d == RUN && state_q == RUN) begin
            if (sum >= DEN_W) begin
                acc_d = sum - DEN_W;
                cen_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end

        // Outputs follow next-state so they switch on the same edge as state.
        rst_out_d  = (state_d != RUN);
        rstn_out_d = (state_d == RUN);
        ready_d    = (state_d == RUN);
        pll_rst_d  = (state_d == PLLRST);
    end

    // State and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            acc_q      <= '0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            rst_out_q  <= 1'b1;
            rstn_out_q <= 1'b0;
            ready_q    <= 1'b0;
            pll_rst_q  <= 1'b0;
            cen_q      <= 1'b0;
            lost_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            sync1_q    <= sync1_d;
            locked_s_q <= locked_s_d;
            rst_out_q  <= rst_out_d;
            rstn_out_q <= rstn_out_d;
            ready_q    <= ready_d;
            pll_rst_q  <= pll_rst_d;
            cen_q      <= cen_d;
            lost_q     <= lost_d;
        end
    end

    assign pll_rst  = pll_rst_q;
    assign rst_out  = rst_out_q;
    assign rstn_out = rstn_out_q;
    assign ready    = ready_q;
    assign cen      = cen_q;
    assign lost_cnt = lost_q;

endmodule
